// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time parameter checks for the fifo_sync_param family.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_level_ok(input int unsigned af, input int unsigned depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_level_ok(input int unsigned ae, input int unsigned depth);
    return ae < depth;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_sync_param: synchronous write, combinational read.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, error pulses
// and selectable standard / first-word-fall-through read port.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  localparam ptr_t One    = ptr_t'(1);
  localparam ptr_t DepthC = ptr_t'(DEPTH);
  localparam ptr_t AfC    = ptr_t'(AF_LEVEL);
  localparam ptr_t AeC    = ptr_t'(AE_LEVEL);

  if (DATA_W < 1) begin : g_bad_width
    $error("fifo_sync_param: DATA_W must be >= 1");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (FWFT > FIFO_FWFT) begin : g_bad_mode
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end

  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic full_q, empty_q, af_q, ae_q, ov_q, uf_q;
  logic wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Acceptance uses only the registered flags, never the incoming requests' effect.
  always_comb begin
    wr_acc   = wr_en && !full_q && !reset;
    rd_acc   = rd_en && !empty_q && !reset;
    wr_ptr_d = wr_acc ? wr_ptr_q + One : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + One : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ov_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DepthC);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AfC);
      ae_q     <= (count_d <= AeC);
      ov_q     <= wr_en && full_q;
      uf_q     <= rd_en && empty_q;
    end
  end

  fifo_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Masked while empty so an unwritten or already-popped entry is never shown.
    assign rd_data  = empty_q ? '0 : ram_rdata;
    assign rd_valid = !empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

  assign full         = full_q;
  assign almost_full  = af_q;
  assign overflow     = ov_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign underflow    = uf_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: flag table, boundary sequences, FWFT and a
// randomised parameter sweep against queue models.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Standard-mode DEPTH=16 instance
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] wd = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, af, ov, empty, ae, uf;
  logic [4:0] count;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .reset(rst), .wr_en(wr), .wr_data(wd), .full(full), .almost_full(af),
    .overflow(ov), .rd_en(rd), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .almost_empty(ae), .underflow(uf), .count(count)
  );

  // FWFT DEPTH=16 instance
  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_wd = '0;
  logic [7:0] f_rd_data;
  logic       f_rv, f_full, f_af, f_ov, f_empty, f_ae, f_uf;
  logic [4:0] f_count;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fw (
    .clk(clk), .reset(rst), .wr_en(f_wr), .wr_data(f_wd), .full(f_full), .almost_full(f_af),
    .overflow(f_ov), .rd_en(f_rd), .rd_data(f_rd_data), .rd_valid(f_rv), .empty(f_empty),
    .almost_empty(f_ae), .underflow(f_uf), .count(f_count)
  );

  // Parameter sweep instances share one random stream; each keeps its own model.
  logic        s_wr = 1'b0, s_rd = 1'b0, s_on = 1'b0;
  logic [31:0] s_wd = '0;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned W  = (g < 2) ? 1 : 32;
    localparam int unsigned D  = (g < 2) ? 2 : 64;
    localparam int unsigned M  = g % 2;
    localparam int unsigned AF = (g < 2) ? 1 : 62;
    localparam int unsigned AE = (g < 2) ? 0 : 2;

    logic [W-1:0]       rdd;
    logic               rv, fu, afl, ovf, em, ael, udf;
    logic [$clog2(D):0] cnt;

    fifo_sync_param #(.DATA_W(W), .DEPTH(D), .FWFT(M), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut (
      .clk(clk), .reset(rst), .wr_en(s_wr), .wr_data(s_wd[W-1:0]), .full(fu),
      .almost_full(afl), .overflow(ovf), .rd_en(s_rd), .rd_data(rdd), .rd_valid(rv),
      .empty(em), .almost_empty(ael), .underflow(udf), .count(cnt)
    );

    logic [W-1:0] mq[$];
    logic [W-1:0] m_rdd = '0;
    logic         m_rv = 1'b0, m_ov = 1'b0, m_uf = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        mq.delete();
        m_rdd = '0;
        m_rv  = 1'b0;
        m_ov  = 1'b0;
        m_uf  = 1'b0;
      end else begin
        automatic bit f = (mq.size() == D);
        automatic bit e = (mq.size() == 0);
        m_ov = s_wr && f;
        m_uf = s_rd && e;
        m_rv = s_rd && !e;
        if (s_rd && !e) m_rdd = mq.pop_front();
        if (s_wr && !f) mq.push_back(s_wd[W-1:0]);
      end
    end

    always @(negedge clk) begin
      if (s_on) begin
        automatic int sz = mq.size();
        chk($sformatf("sw%0d_count", g), 64'(cnt), 64'(sz));
        chk($sformatf("sw%0d_full", g), 64'(fu), 64'(sz == D));
        chk($sformatf("sw%0d_empty", g), 64'(em), 64'(sz == 0));
        chk($sformatf("sw%0d_afull", g), 64'(afl), 64'(sz >= AF));
        chk($sformatf("sw%0d_aempty", g), 64'(ael), 64'(sz <= AE));
        chk($sformatf("sw%0d_ovf", g), 64'(ovf), 64'(m_ov));
        chk($sformatf("sw%0d_udf", g), 64'(udf), 64'(m_uf));
        chk($sformatf("sw%0d_rvalid", g), 64'(rv), (M == 1) ? 64'(sz != 0) : 64'(m_rv));
        if (M == 0 || sz != 0)
          chk($sformatf("sw%0d_rdata", g), 64'(rdd), (M == 1) ? 64'(mq[0]) : 64'(m_rdd));
      end
    end
  end

  // Scoreboard for the standard instance: push on accepted write, pop on accepted read.
  logic [7:0] sb[$];
  int         occ = 0;

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    logic       wacc, racc, eov, euf;
    logic [7:0] exp_d;
    wacc  = w && (occ < 16);
    racc  = r && (occ > 0);
    eov   = w && (occ == 16);
    euf   = r && (occ == 0);
    exp_d = 8'h00;
    wr = w; rd = r; wd = d;
    if (racc) exp_d = sb.pop_front();
    if (wacc) sb.push_back(d);
    occ = occ + int'(wacc) - int'(racc);
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("count", 64'(count), 64'(occ));
    chk("rd_valid", 64'(rd_valid), 64'(racc));
    if (racc) chk("rd_data", 64'(rd_data), 64'(exp_d));
    chk("overflow", 64'(ov), 64'(eov));
    chk("underflow", 64'(uf), 64'(euf));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_aempty"}, 64'(ae), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_afull"}, 64'(af), 64'd0);
    chk({tag, "_rdata"}, 64'(rd_data), 64'd0);
    chk({tag, "_rvalid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_ovf"}, 64'(ov), 64'd0);
    chk({tag, "_udf"}, 64'(uf), 64'd0);
    chk({tag, "_fw_rdata"}, 64'(f_rd_data), 64'd0);
    chk({tag, "_fw_rvalid"}, 64'(f_rv), 64'd0);
    chk({tag, "_fw_empty"}, 64'(f_empty), 64'd1);
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Fill 0x00..0x0F, reject one write, drain, underflow, then both-on-empty.
    for (int i = 0; i < 16; i++)
      vt.push_back('{1'b1, 1'b0, 8'(i), i + 1, (i == 15), 1'b0, (i + 1 >= 14), (i + 1 <= 2)});
    vt.push_back('{1'b1, 1'b0, 8'hFF, 16, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++)
      vt.push_back('{1'b0, 1'b1, 8'h00, 15 - i, 1'b0, (i == 15), (15 - i >= 14), (15 - i <= 2)});
    vt.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("rst0");

    foreach (vt[i]) begin
      step(vt[i].wr, vt[i].rd, vt[i].d);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(vt[i].cnt));
      chk($sformatf("tbl%0d_full", i), 64'(full), 64'(vt[i].full));
      chk($sformatf("tbl%0d_empty", i), 64'(empty), 64'(vt[i].empty));
      chk($sformatf("tbl%0d_afull", i), 64'(af), 64'(vt[i].af));
      chk($sformatf("tbl%0d_aempty", i), 64'(ae), 64'(vt[i].ae));
    end

    // Full plus simultaneous write and read: read wins, write rejected.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    chk("full_before_both", 64'(full), 64'd1);
    step(1'b1, 1'b1, 8'hEE);
    chk("both_full_count", 64'(count), 64'd15);
    chk("both_full_ovf", 64'(ov), 64'd1);

    // Steady state at count 8 across many pointer wraps.
    repeat (7) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i));
      chk("steady_count", 64'(count), 64'd8);
    end
    repeat (8) step(1'b0, 1'b1, 8'h00);
    chk("drain_empty", 64'(empty), 64'd1);

    // Reset mid-stream with a write pending.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    chk("pre_reset_count", 64'(count), 64'd9);
    rst = 1'b1; wr = 1'b1; wd = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    occ = 0;
    sb.delete();
    chk_reset_state("rst1");
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    chk("post_reset_empty", 64'(empty), 64'd1);

    // FWFT: word visible the cycle after its write, gone the cycle after its pop.
    f_wr = 1'b1; f_wd = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    f_wr = 1'b0;
    chk("fw_rdata", 64'(f_rd_data), 64'hA5);
    chk("fw_rvalid", 64'(f_rv), 64'd1);
    chk("fw_empty0", 64'(f_empty), 64'd0);
    chk("fw_count1", 64'(f_count), 64'd1);
    f_rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_rd = 1'b0;
    chk("fw_empty1", 64'(f_empty), 64'd1);
    chk("fw_rvalid0", 64'(f_rv), 64'd0);
    f_wr = 1'b1; f_wd = 8'h11;
    @(posedge clk);
    @(negedge clk);
    f_wd = 8'h22;
    @(posedge clk);
    @(negedge clk);
    f_wr = 1'b0;
    chk("fw_head1", 64'(f_rd_data), 64'h11);
    chk("fw_count2", 64'(f_count), 64'd2);
    f_rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fw_head2", 64'(f_rd_data), 64'h22);
    @(posedge clk);
    @(negedge clk);
    f_rd = 1'b0;
    chk("fw_drained", 64'(f_empty), 64'd1);
    chk("fw_udf0", 64'(f_uf), 64'd0);

    // Randomised sweep: write-heavy, read-heavy, write-heavy, balanced.
    s_on = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      automatic int pw = (ph == 3) ? 50 : ((ph % 2 == 0) ? 85 : 15);
      for (int c = 0; c < 200; c++) begin
        s_wr = ($urandom_range(0, 99) < pw);
        s_rd = ($urandom_range(0, 99) < (100 - pw));
        s_wd = $urandom();
        @(posedge clk);
        @(negedge clk);
      end
    end
    s_wr = 1'b0; s_rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
